// File: rtl/common_pkg.sv
// Shared datapath types used across pipeline stages.
// Combinational only: types and constants, no logic.
// No flow control: nothing here holds state.
package common_pkg;
  parameter int XLEN   = 64;
  parameter int STRB_W = XLEN / 8;

  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/memory_pkg.sv
// Pipeline records and encodings exchanged between execute, memory and decode.
// Combinational only: types and constants, no logic.
// No flow control: nothing here holds state.
package memory_pkg;
  import common_pkg::*;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_LOAD   = 2'd1,
    OP_STORE  = 2'd2,
    OP_BRANCH = 2'd3
  } op_t;

  typedef struct packed {
    op_t  op;
    logic regwrite;
  } control_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Load/store width field, instr[14:12]; bit 2 selects zero extension.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef logic [4:0] creg_addr_t;

  typedef struct packed {
    logic       valid;
    word_t      pc;
    logic [31:0] instr;
    control_t   ctl;
    creg_addr_t dst;
    word_t      aluout;
    word_t      rd2;
  } execute_data_t;

  typedef struct packed {
    logic       valid;
    word_t      pc;
    logic [31:0] instr;
    control_t   ctl;
    creg_addr_t dst;
    word_t      result;
  } memory_data_t;

  typedef struct packed {
    creg_addr_t dst;
    word_t      data;
    logic       ismem;
  } tran_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } mem_state_t;
endpackage

// File: rtl/memory_memaccess.sv
// Access shaping: size, byte strobes, lane-aligned store data, load extraction/extension, misalignment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs directly.
module memaccess
  import common_pkg::*;
  import memory_pkg::*;
(
  input  word_t             addr_i,
  input  logic [2:0]        width_i,
  input  logic              is_mem_i,
  input  logic              is_store_i,
  input  word_t             wdata_i,
  input  word_t             rdata_i,
  output logic [2:0]        size_o,
  output logic [STRB_W-1:0] strobe_o,
  output word_t             wdata_o,
  output word_t             rdata_o,
  output logic              misalign_o
);
  logic [STRB_W-1:0] mask;
  logic              unaligned;
  logic [5:0]        shamt;
  word_t             lane;

  // Decode access width into byte mask and alignment test, then shift to the byte lane.
  always_comb begin
    mask      = '0;
    unaligned = 1'b0;
    case (width_i[1:0])
      2'd0: begin mask = 8'h01; unaligned = 1'b0;            end
      2'd1: begin mask = 8'h03; unaligned = addr_i[0];       end
      2'd2: begin mask = 8'h0F; unaligned = |addr_i[1:0];    end
      default: begin mask = 8'hFF; unaligned = |addr_i[2:0]; end
    endcase
    shamt      = {addr_i[2:0], 3'b000};
    size_o     = {1'b0, width_i[1:0]};
    strobe_o   = is_store_i ? (mask << addr_i[2:0]) : '0;
    wdata_o    = wdata_i << shamt;
    lane       = rdata_i >> shamt;
    misalign_o = is_mem_i & unaligned;
  end

  // Truncate the selected lane to the access size, sign- or zero-extending per width[2].
  always_comb begin
    rdata_o = lane;
    case (width_i[1:0])
      2'd0: rdata_o = width_i[2] ? {{(XLEN-8){1'b0}},  lane[7:0]}  : {{(XLEN-8){lane[7]}},   lane[7:0]};
      2'd1: rdata_o = width_i[2] ? {{(XLEN-16){1'b0}}, lane[15:0]} : {{(XLEN-16){lane[15]}}, lane[15:0]};
      2'd2: rdata_o = width_i[2] ? {{(XLEN-32){1'b0}}, lane[31:0]} : {{(XLEN-32){lane[31]}}, lane[31:0]};
      default: rdata_o = lane;
    endcase
  end
endmodule

// File: rtl/memory.sv
// MEM stage: issues loads/stores on the data bus and registers the result into dataM.
// Latency: one edge to dataM on completion; single-cycle when addr_ok and data_ok arrive with the request.
// Backpressure: stopm holds upstream while an aligned access is outstanding; dataM carries bubbles meanwhile.
module memory
  import common_pkg::*;
  import memory_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  execute_data_t     dataE,
  output memory_data_t      dataM,
  output tran_t             tranm,
  output logic              stopm,
  output logic              misalign,
  output logic              dreq_valid,
  output word_t             dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [STRB_W-1:0] dreq_strobe,
  output word_t             dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  word_t             dresp_data
);
  mem_state_t   state_q, state_d;
  memory_data_t dataM_q, dataM_d;

  logic  is_load, is_store, memop, req_ok, complete;
  word_t load_ext;

  assign is_load  = dataE.valid & (dataE.ctl.op == OP_LOAD);
  assign is_store = dataE.valid & (dataE.ctl.op == OP_STORE);
  assign memop    = is_load | is_store;

  memaccess u_memaccess (
    .addr_i     (dataE.aluout),
    .width_i    (dataE.instr[14:12]),
    .is_mem_i   (memop),
    .is_store_i (is_store),
    .wdata_i    (dataE.rd2),
    .rdata_i    (dresp_data),
    .size_o     (dreq_size),
    .strobe_o   (dreq_strobe),
    .wdata_o    (dreq_data),
    .rdata_o    (load_ext),
    .misalign_o (misalign)
  );

  // A misaligned op never reaches the bus; the exception path takes it instead.
  assign req_ok    = memop & ~misalign;
  assign dreq_addr = dataE.aluout;

  // Completion detection and next-state selection for the bus handshake.
  always_comb begin
    complete = 1'b0;
    state_d  = state_q;
    case (state_q)
      ST_IDLE: begin
        complete = req_ok & dresp_addr_ok & dresp_data_ok;
        if (req_ok && !complete) state_d = dresp_addr_ok ? ST_DATA : ST_ADDR;
      end
      ST_ADDR: begin
        complete = req_ok & dresp_addr_ok & dresp_data_ok;
        if (complete)           state_d = ST_IDLE;
        else if (dresp_addr_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        complete = req_ok & dresp_data_ok;
        if (dresp_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gating makes the request and stall drop the instant reset asserts, regardless of dataE.
  assign dreq_valid = reset & req_ok & (state_q != ST_DATA);
  assign stopm      = reset & req_ok & ~complete;

  // Record that lands in dataM once this instruction retires from the stage.
  always_comb begin
    dataM_d.valid  = dataE.valid;
    dataM_d.pc     = dataE.pc;
    dataM_d.instr  = dataE.instr;
    dataM_d.ctl    = dataE.ctl;
    dataM_d.dst    = dataE.dst;
    dataM_d.result = misalign ? '0 : (is_load ? load_ext : dataE.aluout);
  end

  // Forwarding record for decode; load data is only meaningful in the completion cycle.
  always_comb begin
    tranm.dst   = (dataE.valid & dataE.ctl.regwrite) ? dataE.dst : '0;
    tranm.ismem = is_load;
    tranm.data  = is_load ? load_ext : dataE.aluout;
  end

  // Bus handshake state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Pipeline register: bubble while stalled, otherwise take the execute record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     dataM_q       <= '0;
    else if (stopm) dataM_q.valid <= 1'b0;
    else            dataM_q       <= dataM_d;
  end

  assign dataM = dataM_q;
endmodule
